// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with period-aligned reconfiguration.
// Optional single-cycle edge ticks when CLKDIV_TICK_EN is defined.
module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DIV_DEFAULT = 125,
  parameter int LOW_DEFAULT = 64
) (
  input  logic             clkIN,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_low,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             clkOUT,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick_rise,
  output logic             tick_fall
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_div, w_div_nxt;
  logic [WIDTH-1:0] r_low, w_low_nxt;
  logic [WIDTH-1:0] r_pdiv, w_pdiv_nxt;
  logic [WIDTH-1:0] r_plow, w_plow_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_err, w_err_nxt;
  logic             r_clk, w_clk_nxt;
  logic             w_apply;
  logic             w_bnd;
  logic             w_valid;

  assign w_bnd   = (r_cnt == r_div - ONE);
  assign w_valid = (cfg_div > ONE) && (cfg_low != '0)
                && (cfg_low < cfg_div);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_low_nxt   = r_low;
    w_pdiv_nxt  = r_pdiv;
    w_plow_nxt  = r_plow;
    w_busy_nxt  = r_busy;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_clk_nxt   = r_clk;
    w_apply     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        w_apply   = r_busy;
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt + ONE;
        if (r_cnt == r_low - ONE) w_clk_nxt = 1'b1;
        // Period boundary: the only point where rate or run state may change
        if (w_bnd) begin
          w_cnt_nxt = '0;
          w_clk_nxt = 1'b0;
          w_apply   = r_busy;
          if (!en) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_apply) begin
      w_div_nxt  = r_pdiv;
      w_low_nxt  = r_plow;
      w_busy_nxt = 1'b0;
      w_ack_nxt  = 1'b1;
    end
    if (cfg_load && !r_busy) begin
      if (w_valid) begin
        w_pdiv_nxt = cfg_div;
        w_plow_nxt = cfg_low;
        w_busy_nxt = 1'b1;
      end else begin
        w_err_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clkIN) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= WIDTH'(DIV_DEFAULT);
      r_low   <= WIDTH'(LOW_DEFAULT);
      r_pdiv  <= WIDTH'(DIV_DEFAULT);
      r_plow  <= WIDTH'(LOW_DEFAULT);
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_clk   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_low   <= w_low_nxt;
      r_pdiv  <= w_pdiv_nxt;
      r_plow  <= w_plow_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_clk   <= w_clk_nxt;
    end
  end

  assign cfg_busy = r_busy;
  assign cfg_ack  = r_ack;
  assign cfg_err  = r_err;
  assign clkOUT   = r_clk;
  assign running  = (r_state == S_RUN);
  assign cur_div  = r_div;

`ifdef CLKDIV_TICK_EN
  logic r_tick_rise, r_tick_fall;

  always_ff @(posedge clkIN) begin
    if (rst) begin
      r_tick_rise <= 1'b0;
      r_tick_fall <= 1'b0;
    end else begin
      r_tick_rise <= !r_clk && w_clk_nxt;
      r_tick_fall <= r_clk && !w_clk_nxt;
    end
  end

  assign tick_rise = r_tick_rise;
  assign tick_fall = r_tick_fall;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: period shape, reconfig,
// invalid loads, stop/start and mid-period reset.
module tb_clk_div_prog;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_low;
  logic         cfg_load;
  logic         cfg_busy;
  logic         cfg_ack;
  logic         cfg_err;
  logic         clk_out;
  logic         running;
  logic [W-1:0] cur_div;
`ifdef CLKDIV_TICK_EN
  logic         tick_rise;
  logic         tick_fall;
`endif

  clk_div_prog #(
    .WIDTH(W),
    .DIV_DEFAULT(125),
    .LOW_DEFAULT(64)
  ) dut (
    .clkIN(clk),
    .rst(rst),
    .en(en),
    .cfg_div(cfg_div),
    .cfg_low(cfg_low),
    .cfg_load(cfg_load),
    .cfg_busy(cfg_busy),
    .cfg_ack(cfg_ack),
    .cfg_err(cfg_err),
    .clkOUT(clk_out),
    .running(running),
    .cur_div(cur_div)
`ifdef CLKDIV_TICK_EN
    ,
    .tick_rise(tick_rise),
    .tick_fall(tick_fall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input logic v, output int n);
    n = 0;
    while (clk_out !== v && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic measure_period(input string tag, input int lo,
                                input int hi);
    int n;
    push({tag, "_low"}, lo);
    wait_for(1'b1, n);
    pop_check(n);
`ifdef CLKDIV_TICK_EN
    push({tag, "_tick_rise"}, 1);
    pop_check(tick_rise);
`endif
    push({tag, "_high"}, hi);
    wait_for(1'b0, n);
    pop_check(n);
`ifdef CLKDIV_TICK_EN
    push({tag, "_tick_fall"}, 1);
    pop_check(tick_fall);
`endif
  endtask

  task automatic load(input int d, input int l);
    cfg_div  = W'(d);
    cfg_low  = W'(l);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    push({tag, "_running"}, 0);  pop_check(running);
    push({tag, "_clkout"}, 0);   pop_check(clk_out);
    push({tag, "_cur_div"}, 125); pop_check(cur_div);
    push({tag, "_busy"}, 0);     pop_check(cfg_busy);
    push({tag, "_ack"}, 0);      pop_check(cfg_ack);
    push({tag, "_err"}, 0);      pop_check(cfg_err);
`ifdef CLKDIV_TICK_EN
    push({tag, "_tick_rise"}, 0); pop_check(tick_rise);
    push({tag, "_tick_fall"}, 0); pop_check(tick_fall);
`endif
  endtask

  int n;
  int highs;
  int bad_d[3] = '{1, 8, 8};
  int bad_l[3] = '{0, 8, 0};

  initial begin
    rst = 1'b1; en = 1'b0;
    cfg_div = '0; cfg_low = '0; cfg_load = 1'b0;
    step(); step();
    check_reset_state("rst0");

    // defaults: 64 low / 61 high
    rst = 1'b0;
    step();
    en = 1'b1;
    push("run_latency", 1);
    step();
    pop_check(running);
    measure_period("def_p0", 64, 61);

    // reconfigure mid-period; a second load while busy is ignored
    repeat (20) step();
    load(10, 5);
    push("busy_after_load", 1);
    pop_check(cfg_busy);
    repeat (5) step();
    load(20, 7);
    n = 6;
    push("busy_ignore_err", 0);
    pop_check(cfg_err);
    push("busy_ignore_busy", 1);
    pop_check(cfg_busy);
    while (cfg_ack !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    push("ack_latency", 104);
    pop_check(n);
    push("ack_cur_div", 10);   pop_check(cur_div);
    push("ack_busy_clr", 0);   pop_check(cfg_busy);
    push("ack_clkout", 0);     pop_check(clk_out);
    step();
    push("ack_width", 0);      pop_check(cfg_ack);
    push("new_p0_low", 4);
    wait_for(1'b1, n);
    pop_check(n);
    push("new_p0_high", 5);
    wait_for(1'b0, n);
    pop_check(n);
    measure_period("new_p1", 5, 5);
    measure_period("new_p2", 5, 5);
    push("no_20_cur_div", 10); pop_check(cur_div);

    // invalid loads
    for (int i = 0; i < 3; i++) begin
      load(bad_d[i], bad_l[i]);
      push($sformatf("bad%0d_err", i), 1);  pop_check(cfg_err);
      push($sformatf("bad%0d_busy", i), 0); pop_check(cfg_busy);
      step();
      push($sformatf("bad%0d_err_w", i), 0);  pop_check(cfg_err);
      push($sformatf("bad%0d_cur", i), 10);   pop_check(cur_div);
    end

    // stop mid-period, then restart
    wait_for(1'b1, n);
    wait_for(1'b0, n);
    step(); step();
    en = 1'b0;
    n = 0;
    highs = 0;
    while (running !== 1'b0 && n < 400) begin
      step();
      n++;
      if (clk_out === 1'b1) highs++;
    end
    push("stop_latency", 8);  pop_check(n);
    push("stop_highs", 5);    pop_check(highs);
    push("stop_clkout", 0);   pop_check(clk_out);
`ifdef CLKDIV_TICK_EN
    push("stop_tick_fall", 1); pop_check(tick_fall);
`endif
    repeat (3) step();
    push("idle_running", 0);  pop_check(running);
    push("idle_clkout", 0);   pop_check(clk_out);
    en = 1'b1;
    push("restart_rise", 6);
    wait_for(1'b1, n);
    pop_check(n);

    // reset at count=70 with a load pending
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    repeat (60) step();
    load(10, 5);
    push("pend_busy", 1);     pop_check(cfg_busy);
    repeat (9) step();
    rst = 1'b1;
    step();
    check_reset_state("rst70");
    rst = 1'b0;
    step();
    measure_period("post_rst", 64, 61);
    push("post_rst_cur", 125); pop_check(cur_div);
    push("post_rst_busy", 0);  pop_check(cfg_busy);

    en = 1'b0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
